// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: ATM session FSM with PIN retry lockout, on-chip
// balance with funds check and saturating deposit, and idle timeout.
module atm_session_ctrl #(
  parameter int BAL_W     = 16,
  parameter int PIN_W     = 16,
  parameter logic [PIN_W-1:0] PIN_VALUE = 16'h1234,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 1000,
  parameter int INIT_BAL  = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             card,
  input  logic [PIN_W-1:0] pin,
  input  logic             pin_valid,
  input  logic             choice,
  input  logic             choice_valid,
  input  logic [1:0]       amount,
  input  logic             amount_valid,
  output logic [2:0]       dep_done,
  output logic [2:0]       wd_done,
  output logic             denied,
  output logic             card_eject,
  output logic             card_retained,
  output logic [BAL_W-1:0] balance,
  output logic [2:0]       state_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PIN    = 3'd1,
    S_MENU   = 3'd2,
    S_AMOUNT = 3'd3,
    S_EJECT  = 3'd4,
    S_LOCKED = 3'd5
  } state_e;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0] TRY_LAST = 4'(MAX_TRIES - 1);
  localparam logic [BAL_W:0] BAL_MAX = {1'b0, {BAL_W{1'b1}}};

  state_e           state_q, state_d;
  logic [3:0]       tries_q, tries_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic             mode_q, mode_d;
  logic [2:0]       dep_q, dep_d;
  logic [2:0]       wd_q, wd_d;
  logic             den_q, den_d;
  logic             eject_q, retained_q;

  logic             waiting;
  logic             acc;
  logic [BAL_W:0]   units;
  logic [BAL_W:0]   sum;
  logic [2:0]       oh;

  always_comb begin
    units = '0;
    oh    = '0;
    case (amount)
      2'b01: begin units = (BAL_W+1)'(1); oh = 3'b001; end
      2'b10: begin units = (BAL_W+1)'(2); oh = 3'b010; end
      2'b11: begin units = (BAL_W+1)'(4); oh = 3'b100; end
      default: ;
    endcase
  end

  assign sum = {1'b0, bal_q} + units;

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    timer_d = timer_q;
    bal_d   = bal_q;
    mode_d  = mode_q;
    dep_d   = '0;
    wd_d    = '0;
    den_d   = 1'b0;
    acc     = 1'b0;
    waiting = (state_q == S_PIN) || (state_q == S_MENU) ||
              (state_q == S_AMOUNT);
    // Card pull aborts a session before any strobe is considered
    if (waiting && !card) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (card) begin
          state_d = S_PIN;
          tries_d = '0;
          timer_d = '0;
        end
        S_PIN: if (pin_valid) begin
          acc = 1'b1;
          if (pin == PIN_VALUE) begin
            state_d = S_MENU;
            tries_d = '0;
          end else if (tries_q == TRY_LAST) begin
            state_d = S_LOCKED;
          end else begin
            tries_d = tries_q + 4'd1;
            den_d   = 1'b1;
          end
        end
        S_MENU: if (choice_valid) begin
          acc     = 1'b1;
          mode_d  = choice;
          state_d = S_AMOUNT;
        end
        S_AMOUNT: if (amount_valid) begin
          acc = 1'b1;
          if (amount == 2'b00) begin
            state_d = S_EJECT;
          end else if (!mode_q) begin
            bal_d   = (sum > BAL_MAX) ? BAL_MAX[BAL_W-1:0]
                                      : sum[BAL_W-1:0];
            dep_d   = oh;
            state_d = S_EJECT;
          end else if (units <= {1'b0, bal_q}) begin
            bal_d   = bal_q - units[BAL_W-1:0];
            wd_d    = oh;
            state_d = S_EJECT;
          end else begin
            den_d = 1'b1;
          end
        end
        S_EJECT: if (!card) state_d = S_IDLE;
        S_LOCKED: ;
        default: state_d = S_IDLE;
      endcase
      if (waiting) begin
        if (acc) timer_d = '0;
        else if (timer_q == T_LAST) state_d = S_EJECT;
        else timer_d = timer_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tries_q    <= '0;
      timer_q    <= '0;
      bal_q      <= BAL_W'(INIT_BAL);
      mode_q     <= 1'b0;
      dep_q      <= '0;
      wd_q       <= '0;
      den_q      <= 1'b0;
      eject_q    <= 1'b0;
      retained_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tries_q    <= tries_d;
      timer_q    <= timer_d;
      bal_q      <= bal_d;
      mode_q     <= mode_d;
      dep_q      <= dep_d;
      wd_q       <= wd_d;
      den_q      <= den_d;
      eject_q    <= (state_d == S_EJECT);
      retained_q <= (state_d == S_LOCKED);
    end
  end

  assign dep_done      = dep_q;
  assign wd_done       = wd_q;
  assign denied        = den_q;
  assign card_eject    = eject_q;
  assign card_retained = retained_q;
  assign balance       = bal_q;
  assign state_out     = state_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: two instances (16-bit and 4-bit balance)
// share stimulus; a session-level model is checked every cycle.
module tb_atm_session_ctrl;

  localparam int TMO = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic card = 1'b0;
  logic [15:0] pin = '0;
  logic pin_valid = 1'b0;
  logic choice = 1'b0;
  logic choice_valid = 1'b0;
  logic [1:0] amount = '0;
  logic amount_valid = 1'b0;

  logic [2:0] a_dep, a_wd, a_st, b_dep, b_wd, b_st;
  logic a_den, a_ej, a_ret, b_den, b_ej, b_ret;
  logic [15:0] a_bal;
  logic [3:0] b_bal;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  atm_session_ctrl #(.BAL_W(16), .TIMEOUT(TMO), .INIT_BAL(20)) dut_a (
    .clock(clock), .reset(reset), .card(card),
    .pin(pin), .pin_valid(pin_valid),
    .choice(choice), .choice_valid(choice_valid),
    .amount(amount), .amount_valid(amount_valid),
    .dep_done(a_dep), .wd_done(a_wd), .denied(a_den),
    .card_eject(a_ej), .card_retained(a_ret),
    .balance(a_bal), .state_out(a_st)
  );

  atm_session_ctrl #(.BAL_W(4), .TIMEOUT(TMO), .INIT_BAL(14)) dut_b (
    .clock(clock), .reset(reset), .card(card),
    .pin(pin), .pin_valid(pin_valid),
    .choice(choice), .choice_valid(choice_valid),
    .amount(amount), .amount_valid(amount_valid),
    .dep_done(b_dep), .wd_done(b_wd), .denied(b_den),
    .card_eject(b_ej), .card_retained(b_ret),
    .balance(b_bal), .state_out(b_st)
  );

  // Session model: st 0 idle,1 pin,2 menu,3 amount,4 eject,5 locked
  typedef struct {
    int st;
    int tries;
    int idle;
    int bal;
    bit wd_mode;
    logic [2:0] dep;
    logic [2:0] wd;
    bit den;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step(mdl_t m, int init_bal, int max_bal);
    mdl_t n = m;
    int units;
    bit took = 1'b0;
    bit waiting;
    n.dep = '0;
    n.wd = '0;
    n.den = 1'b0;
    if (reset) begin
      n.st = 0; n.tries = 0; n.idle = 0;
      n.bal = init_bal; n.wd_mode = 1'b0;
      return n;
    end
    waiting = (m.st >= 1 && m.st <= 3);
    if (waiting && !card) begin
      n.st = 0;
      return n;
    end
    units = (amount == 2'b11) ? 4 : int'(amount);
    case (m.st)
      0: if (card) begin n.st = 1; n.tries = 0; n.idle = 0; end
      1: if (pin_valid) begin
        took = 1'b1;
        if (pin == 16'h1234) begin n.st = 2; n.tries = 0; end
        else begin
          n.tries = m.tries + 1;
          if (n.tries == 3) n.st = 5;
          else n.den = 1'b1;
        end
      end
      2: if (choice_valid) begin
        took = 1'b1; n.wd_mode = choice; n.st = 3;
      end
      3: if (amount_valid) begin
        took = 1'b1;
        if (units == 0) n.st = 4;
        else if (!m.wd_mode) begin
          n.bal = (m.bal + units > max_bal) ? max_bal : m.bal + units;
          n.dep = 3'(units);
          n.st = 4;
        end else if (units <= m.bal) begin
          n.bal = m.bal - units;
          n.wd = 3'(units);
          n.st = 4;
        end else n.den = 1'b1;
      end
      4: if (!card) n.st = 0;
      default: ;
    endcase
    if (waiting) begin
      if (took) n.idle = 0;
      else if (m.idle + 1 == TMO) n.st = 4;
      else n.idle = m.idle + 1;
    end
    return n;
  endfunction

  task automatic cmp(input string name, input mdl_t m,
                     input logic [2:0] st, input logic [2:0] dep,
                     input logic [2:0] wd, input logic den,
                     input logic ej, input logic ret,
                     input logic [15:0] bal);
    logic [27:0] exp_v, act_v;
    exp_v = {3'(m.st), m.dep, m.wd, m.den, m.st == 4, m.st == 5,
             16'(m.bal)};
    act_v = {st, dep, wd, den, ej, ret, bal};
    n_vec++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h required %h",
               name, cyc, act_v, exp_v);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act,
                     input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d required %0d",
               name, cyc, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    ma = step(ma, 20, 65535);
    mb = step(mb, 14, 15);
    cyc++;
    #1;
    cmp("model_a", ma, a_st, a_dep, a_wd, a_den, a_ej, a_ret, a_bal);
    cmp("model_b", mb, b_st, b_dep, b_wd, b_den, b_ej, b_ret,
        {12'b0, b_bal});
  endtask

  task automatic do_pin(input logic [15:0] v);
    pin = v; pin_valid = 1'b1; tick(); pin_valid = 1'b0;
  endtask

  task automatic do_choice(input logic c);
    choice = c; choice_valid = 1'b1; tick(); choice_valid = 1'b0;
  endtask

  task automatic do_amt(input logic [1:0] a);
    amount = a; amount_valid = 1'b1; tick(); amount_valid = 1'b0;
  endtask

  task automatic start();
    card = 1'b1; tick(); do_pin(16'h1234);
  endtask

  task automatic pull();
    card = 1'b0; tick();
  endtask

  task automatic session(input logic c, input logic [1:0] a);
    start(); do_choice(c); do_amt(a); pull();
  endtask

  initial begin
    tick(); tick();
    lit("rst_state", 32'(a_st), 0);
    lit("rst_bal_a", 32'(a_bal), 20);
    lit("rst_bal_b", 32'(b_bal), 14);
    reset = 1'b0;
    tick();

    start(); do_choice(1'b0); do_amt(2'b11);
    lit("dep_pulse_a", 32'(a_dep), 4);
    lit("dep_bal_a", 32'(a_bal), 24);
    lit("sat_pulse_b", 32'(b_dep), 4);
    lit("sat_bal_b", 32'(b_bal), 15);
    lit("dep_eject", 32'(a_ej), 1);
    tick();
    lit("dep_one_cycle", 32'(a_dep), 0);
    pull();
    lit("pull_idle", 32'(a_st), 0);

    start();
    lit("pin_ok_menu", 32'(a_st), 2);
    do_choice(1'b1);
    lit("menu_amount", 32'(a_st), 3);
    do_amt(2'b10);
    lit("wd_pulse", 32'(a_wd), 2);
    lit("wd_bal", 32'(a_bal), 22);
    lit("wd_eject", 32'(a_ej), 1);
    pull();
    lit("eject_off", 32'(a_ej), 0);

    repeat (4) session(1'b1, 2'b11);
    session(1'b1, 2'b10);
    session(1'b1, 2'b01);
    lit("drain_bal_a", 32'(a_bal), 3);
    lit("drain_bal_b", 32'(b_bal), 0);

    start(); do_choice(1'b1); do_amt(2'b11);
    lit("nsf_denied", 32'(a_den), 1);
    lit("nsf_state", 32'(a_st), 3);
    lit("nsf_bal", 32'(a_bal), 3);
    tick();
    lit("nsf_one_cycle", 32'(a_den), 0);
    do_amt(2'b01);
    lit("nsf_retry_wd", 32'(a_wd), 1);
    lit("nsf_retry_bal", 32'(a_bal), 2);
    pull();

    card = 1'b1; tick();
    do_pin(16'h1111);
    lit("bad1_denied", 32'(a_den), 1);
    do_pin(16'h4321);
    lit("bad2_denied", 32'(a_den), 1);
    do_pin(16'h0000);
    lit("bad3_no_deny", 32'(a_den), 0);
    lit("bad3_locked", 32'(a_st), 5);
    lit("retained", 32'(a_ret), 1);
    pull();
    do_pin(16'h1234);
    lit("lock_holds", 32'(a_st), 5);
    reset = 1'b1; tick(); reset = 1'b0;
    lit("unlock_idle", 32'(a_st), 0);
    lit("unlock_bal", 32'(a_bal), 20);

    start();
    repeat (TMO - 1) tick();
    lit("to_wait", 32'(a_st), 2);
    tick();
    lit("to_fire", 32'(a_st), 4);
    pull();

    start();
    repeat (TMO - 1) tick();
    do_choice(1'b1);
    lit("to_strobe_wins", 32'(a_st), 3);
    repeat (TMO - 1) tick();
    lit("to_cleared", 32'(a_st), 3);
    tick();
    lit("to_fire2", 32'(a_st), 4);
    pull();

    session(1'b0, 2'b01);
    start(); do_choice(1'b1);
    amount = 2'b10; amount_valid = 1'b1; card = 1'b0;
    tick();
    amount_valid = 1'b0;
    lit("abort_idle", 32'(a_st), 0);
    lit("abort_no_wd", 32'(a_wd), 0);
    lit("abort_bal", 32'(a_bal), 21);

    start(); do_choice(1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    lit("midrst_state", 32'(a_st), 0);
    lit("midrst_bal", 32'(a_bal), 20);
    lit("midrst_eject", 32'(a_ej), 0);
    pull();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
